// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, EX operand selects
// and the width of the load-use bubble counter.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    HALTED  = 2'b10
  } hazard_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // LOAD_LAT is at most 7, so LOAD_LAT-1 always fits in three bits.
  localparam int LDCNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Stage-register fields into the hazard controller and its pipeline-control outputs.
// The datapath side is the master; the hazard controller is the slave.
interface hazard_ctrl_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) ();
  import hazard_ctrl_unit_pkg::*;

  logic             ihit;
  logic             dhit;
  logic             exmem_ren;
  logic             exmem_wen;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic [REG_W-1:0] idex_rs;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] idex_wsel;
  logic [REG_W-1:0] exmem_wsel;
  logic [REG_W-1:0] memwb_wsel;
  logic             idex_regwen;
  logic             exmem_regwen;
  logic             memwb_regwen;
  logic             idex_memread;
  logic             exmem_brtaken;
  logic             memwb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ihit, dhit, exmem_ren, exmem_wen,
    output ifid_rs, ifid_rt, idex_rs, idex_rt,
    output idex_wsel, exmem_wsel, memwb_wsel,
    output idex_regwen, exmem_regwen, memwb_regwen,
    output idex_memread, exmem_brtaken, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush,
    input  fwd_a, fwd_b, halted, stall_count
  );

  modport slave (
    input  ihit, dhit, exmem_ren, exmem_wen,
    input  ifid_rs, ifid_rt, idex_rs, idex_rt,
    input  idex_wsel, exmem_wsel, memwb_wsel,
    input  idex_regwen, exmem_regwen, memwb_regwen,
    input  idex_memread, exmem_brtaken, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush,
    output fwd_a, fwd_b, halted, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_unit_forward_sel.sv
// Chooses the EX operand source for one register index.
// EX/MEM beats MEM/WB, register 0 is never forwarded, and FWD_EN=0 always reads the RF.
module forward_sel
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_exmem_regwen,
  input  logic [REG_W-1:0] i_exmem_wsel,
  input  logic             i_memwb_regwen,
  input  logic [REG_W-1:0] i_memwb_wsel,
  output fwd_sel_t         o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_regwen && (i_exmem_wsel != '0) && (i_exmem_wsel == i_src);
  assign w_memwb_hit = i_memwb_regwen && (i_memwb_wsel != '0) && (i_memwb_wsel == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (FWD_EN != 0) begin
      if (w_exmem_hit) begin
        o_sel = FWD_EXMEM;
      end else if (w_memwb_hit) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central pipeline control for the 5-stage core: latch enables/flushes, PC stall,
// load-use bubbling, branch squash, sticky halt, EX forwarding and a stall counter.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  hazard_ctrl_unit_if.slave hz
);

  hazard_state_t      r_state;
  hazard_state_t      w_state_nxt;
  logic [LDCNT_W-1:0] r_ldcnt;
  logic [LDCNT_W-1:0] w_ldcnt_nxt;
  logic [CNT_W-1:0]   r_stall_count;

  logic     w_halted;
  logic     w_mem_wait;
  logic     w_ld_use;
  logic     w_raw_idex;
  logic     w_raw_exmem;
  logic     w_raw_stall;
  logic     w_stall_inc;
  logic     w_pc_en;
  logic     w_ifid_en;
  logic     w_idex_en;
  logic     w_exmem_en;
  logic     w_memwb_en;
  logic     w_ifid_flush;
  logic     w_idex_flush;
  logic     w_exmem_flush;
  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;

  assign w_halted   = !RST && ((r_state == HALTED) || hz.memwb_halt);
  assign w_mem_wait = (hz.exmem_ren || hz.exmem_wen) && !hz.dhit;

  assign w_raw_idex  = hz.idex_regwen && (hz.idex_wsel != '0) &&
                       ((hz.idex_wsel == hz.ifid_rs) || (hz.idex_wsel == hz.ifid_rt));
  assign w_raw_exmem = hz.exmem_regwen && (hz.exmem_wsel != '0) &&
                       ((hz.exmem_wsel == hz.ifid_rs) || (hz.exmem_wsel == hz.ifid_rt));
  assign w_ld_use    = hz.idex_memread && w_raw_idex;
  // MEM/WB needs no check: the register file writes before it reads.
  assign w_raw_stall = (FWD_EN == 0) && (w_raw_idex || w_raw_exmem);

  always_comb begin
    w_pc_en       = 1'b0;
    w_ifid_en     = 1'b0;
    w_idex_en     = 1'b0;
    w_exmem_en    = 1'b0;
    w_memwb_en    = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_state_nxt   = r_state;
    w_ldcnt_nxt   = r_ldcnt;

    if (RST) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_halted) begin
      w_state_nxt = HALTED;
    end else if (w_mem_wait) begin
      // Full freeze: nothing moves and the bubble counter holds.
    end else if (hz.exmem_brtaken) begin
      // A flush loads the NOP on its own, so flushed latches keep their enable low.
      w_pc_en       = 1'b1;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_memwb_en    = 1'b1;
      w_state_nxt   = RUN;
      w_ldcnt_nxt   = '0;
    end else if ((r_state == LDSTALL) || w_ld_use || w_raw_stall) begin
      w_idex_flush = 1'b1;
      w_exmem_en   = 1'b1;
      w_memwb_en   = 1'b1;
      if (r_state == LDSTALL) begin
        w_ldcnt_nxt = r_ldcnt - LDCNT_W'(1);
        if (r_ldcnt <= LDCNT_W'(1)) begin
          w_state_nxt = RUN;
        end
      end else if (w_ld_use && (LOAD_LAT > 1)) begin
        w_ldcnt_nxt = LDCNT_W'(LOAD_LAT - 1);
        w_state_nxt = LDSTALL;
      end
    end else if (!hz.ihit) begin
      w_ifid_flush = 1'b1;
      w_idex_en    = 1'b1;
      w_exmem_en   = 1'b1;
      w_memwb_en   = 1'b1;
    end else begin
      w_pc_en    = 1'b1;
      w_ifid_en  = 1'b1;
      w_idex_en  = 1'b1;
      w_exmem_en = 1'b1;
      w_memwb_en = 1'b1;
    end
  end

  forward_sel #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_a (
    .i_src          (hz.idex_rs),
    .i_exmem_regwen (hz.exmem_regwen),
    .i_exmem_wsel   (hz.exmem_wsel),
    .i_memwb_regwen (hz.memwb_regwen),
    .i_memwb_wsel   (hz.memwb_wsel),
    .o_sel          (w_fwd_a)
  );

  forward_sel #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_b (
    .i_src          (hz.idex_rt),
    .i_exmem_regwen (hz.exmem_regwen),
    .i_exmem_wsel   (hz.exmem_wsel),
    .i_memwb_regwen (hz.memwb_regwen),
    .i_memwb_wsel   (hz.memwb_wsel),
    .o_sel          (w_fwd_b)
  );

  assign w_stall_inc = !RST && !w_halted && !w_pc_en && (r_stall_count != '1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= RUN;
      r_ldcnt       <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ldcnt <= w_ldcnt_nxt;
      if (w_stall_inc) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign hz.pc_en       = w_pc_en;
  assign hz.ifid_en     = w_ifid_en;
  assign hz.idex_en     = w_idex_en;
  assign hz.exmem_en    = w_exmem_en;
  assign hz.memwb_en    = w_memwb_en;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_flush  = w_idex_flush;
  assign hz.exmem_flush = w_exmem_flush;
  assign hz.fwd_a       = RST ? FWD_RF : w_fwd_a;
  assign hz.fwd_b       = RST ? FWD_RF : w_fwd_b;
  assign hz.halted      = w_halted;
  assign hz.stall_count = r_stall_count;

endmodule
